uart_cmd_frame_decoder: RTL and testbench



---
 rtl/beep_cmd_pkg.sv | 33 +++
 rtl/frame_timeout_cnt.sv | 29 ++
 rtl/uart_cmd_frame_decoder.sv | 152 +++++++++++++++
 tb/tb_uart_cmd_frame_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_cmd_pkg.sv
// Shared types and constants for the beep command frame decoder.
// Frame: header(4) period(4) high(4) num(2) tail(4), every field MSB first.
package beep_cmd_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_HDR,
        S_DATA,
        S_TAIL,
        S_CHECK
    } state_t;

    localparam int FRAME_LEN  = 18;
    localparam int PERIOD_IDX = 4;
    localparam int HIGH_IDX   = 8;
    localparam int NUM_IDX    = 12;
    localparam int TAIL_IDX   = 14;

    localparam logic [1:0] ERR_TAIL  = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_PARAM = 2'd3;

    // Byte sel of a 32-bit word, sel 0 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        case (sel)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle counter: clears on i_clr, counts while i_en, and flags
// expiry on the edge where the count would reach TIMEOUT_CYCLES-1.
module frame_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte arriving on the expiry edge clears the count and suppresses expiry.
    assign o_expire = i_en && !i_clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_frame_decoder.sv
// Hunts the UART byte stream for 18-byte beep command frames, validates them
// and publishes period/high/num to the PWM generator with a one-cycle strobe.
//
// state   | meaning
// S_HUNT  | waiting for the first header byte
// S_HDR   | matching header bytes 1-3, resyncing on a repeated first byte
// S_DATA  | shifting in period, high and num fields
// S_TAIL  | matching tail bytes
// S_CHECK | range check of the captured parameters, publish or reject
module uart_cmd_frame_decoder
    import beep_cmd_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [31:0] HDR_WORD       = 32'hAA55A55A,
    parameter logic [31:0] TAIL_WORD      = 32'hCC33C33C
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_en,
    input  logic [7:0]  i_rx_data,
    output logic        o_beep_en,
    output logic [31:0] o_beep_periord,
    output logic [31:0] o_beep_high,
    output logic [15:0] o_beep_num,
    output logic        o_frm_err,
    output logic [1:0]  o_err_code
);

    state_t      state;
    logic [4:0]  idx;
    logic [31:0] sh_period;
    logic [31:0] sh_high;
    logic [15:0] sh_num;

    logic        tmo_clr;
    logic        tmo_en;
    logic        tmo_expire;
    logic [7:0]  hdr_first;
    logic [7:0]  hdr_exp;
    logic [7:0]  tail_exp;

    assign hdr_first = word_byte(HDR_WORD, 2'd0);
    assign hdr_exp   = word_byte(HDR_WORD, idx[1:0]);
    assign tail_exp  = word_byte(TAIL_WORD, 2'(idx - 5'(TAIL_IDX)));

    assign tmo_clr = i_rx_en || (state == S_HUNT);
    assign tmo_en  = (state == S_HDR) || (state == S_DATA) || (state == S_TAIL);

    frame_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (tmo_clr),
        .i_en     (tmo_en),
        .o_expire (tmo_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_HUNT;
            idx            <= '0;
            sh_period      <= '0;
            sh_high        <= '0;
            sh_num         <= '0;
            o_beep_en      <= 1'b0;
            o_beep_periord <= '0;
            o_beep_high    <= '0;
            o_beep_num     <= '0;
            o_frm_err      <= 1'b0;
            o_err_code     <= '0;
        end else begin
            o_beep_en <= 1'b0;
            o_frm_err <= 1'b0;
            if (tmo_expire) begin
                o_frm_err  <= 1'b1;
                o_err_code <= ERR_TMO;
                state      <= S_HUNT;
                idx        <= '0;
            end else begin
                case (state)
                    S_HUNT: begin
                        if (i_rx_en && i_rx_data == hdr_first) begin
                            state <= S_HDR;
                            idx   <= 5'd1;
                        end
                    end
                    S_HDR: begin
                        if (i_rx_en) begin
                            if (i_rx_data == hdr_exp) begin
                                idx <= idx + 5'd1;
                                if (idx == 5'd3) state <= S_DATA;
                            end else if (i_rx_data == hdr_first) begin
                                idx <= 5'd1;
                            end else begin
                                state <= S_HUNT;
                                idx   <= '0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (i_rx_en) begin
                            if (idx < 5'(HIGH_IDX)) begin
                                sh_period <= {sh_period[23:0], i_rx_data};
                            end else if (idx < 5'(NUM_IDX)) begin
                                sh_high <= {sh_high[23:0], i_rx_data};
                            end else begin
                                sh_num <= {sh_num[7:0], i_rx_data};
                            end
                            idx <= idx + 5'd1;
                            if (idx == 5'(TAIL_IDX - 1)) state <= S_TAIL;
                        end
                    end
                    S_TAIL: begin
                        if (i_rx_en) begin
                            if (i_rx_data != tail_exp) begin
                                // The offending byte is consumed here, never re-hunted.
                                o_frm_err  <= 1'b1;
                                o_err_code <= ERR_TAIL;
                                state      <= S_HUNT;
                                idx        <= '0;
                            end else if (idx == 5'(FRAME_LEN - 1)) begin
                                state <= S_CHECK;
                                idx   <= '0;
                            end else begin
                                idx <= idx + 5'd1;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (sh_period != '0 && sh_high <= sh_period) begin
                            o_beep_periord <= sh_period;
                            o_beep_high    <= sh_high;
                            o_beep_num     <= sh_num;
                            o_beep_en      <= 1'b1;
                        end else begin
                            o_frm_err  <= 1'b1;
                            o_err_code <= ERR_PARAM;
                        end
                        state <= S_HUNT;
                        idx   <= '0;
                    end
                    default: begin
                        state <= S_HUNT;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// Directed bench for uart_cmd_frame_decoder with a queue-based frame model
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_uart_cmd_frame_decoder;

    localparam int TMO = 3000;
    localparam int GAP = 20;
    localparam logic [31:0] TAIL_OK  = 32'hCC33C33C;
    localparam logic [31:0] TAIL_BAD = 32'hCC33C33D;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rx_en = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_beep_en;
    logic [31:0] o_beep_periord;
    logic [31:0] o_beep_high;
    logic [15:0] o_beep_num;
    logic        o_frm_err;
    logic [1:0]  o_err_code;

    always #10 i_clk = ~i_clk;

    uart_cmd_frame_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_rx_en        (i_rx_en),
        .i_rx_data      (i_rx_data),
        .o_beep_en      (o_beep_en),
        .o_beep_periord (o_beep_periord),
        .o_beep_high    (o_beep_high),
        .o_beep_num     (o_beep_num),
        .o_frm_err      (o_frm_err),
        .o_err_code     (o_err_code)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // model state
    logic [7:0]  hdr_b [4] = '{8'hAA, 8'h55, 8'hA5, 8'h5A};
    logic [7:0]  tail_b[4] = '{8'hCC, 8'h33, 8'hC3, 8'h3C};
    logic [7:0]  fq[$];
    int          m_last_rx = 0;
    bit          chk_pend = 0;
    logic        m_en = 1'b0, m_err = 1'b0;
    logic [1:0]  m_code = 2'd0;
    logic [31:0] m_per = '0, m_high = '0;
    logic [15:0] m_num = '0;

    // observation bookkeeping
    int n_en = 0, n_err = 0, en_cyc = 0, err_cyc = 0, last_rx_cyc = 0;

    task automatic model_byte(input logic [7:0] b);
        int n;
        n = fq.size();
        if (n < 4) begin
            if (b == hdr_b[n]) fq.push_back(b);
            else if (b == hdr_b[0]) begin fq.delete(); fq.push_back(b); end
            else fq.delete();
        end else if (n < 14) begin
            fq.push_back(b);
        end else if (b != tail_b[n-14]) begin
            m_err = 1'b1; m_code = 2'd1; fq.delete();
        end else begin
            fq.push_back(b);
            if (fq.size() == 18) chk_pend = 1;
        end
    endtask

    initial begin
        logic [31:0] per, hi;
        logic [15:0] num;
        forever begin
            @(posedge i_clk);
            cyc++;
            m_en = 1'b0;
            m_err = 1'b0;
            if (i_rst) begin
                fq.delete(); chk_pend = 0;
                m_code = 0; m_per = 0; m_high = 0; m_num = 0;
            end else if (chk_pend) begin
                chk_pend = 0;
                per = {fq[4], fq[5], fq[6], fq[7]};
                hi  = {fq[8], fq[9], fq[10], fq[11]};
                num = {fq[12], fq[13]};
                if (per != 0 && hi <= per) begin
                    m_per = per; m_high = hi; m_num = num; m_en = 1'b1;
                end else begin
                    m_err = 1'b1; m_code = 2'd3;
                end
                fq.delete();
            end else if (i_rx_en) begin
                m_last_rx = cyc;
                model_byte(i_rx_data);
            end else if (fq.size() > 0 && cyc - m_last_rx == TMO - 1) begin
                m_err = 1'b1; m_code = 2'd2; fq.delete();
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            tests++;
            if (o_beep_en !== m_en || o_frm_err !== m_err || o_err_code !== m_code ||
                o_beep_periord !== m_per || o_beep_high !== m_high || o_beep_num !== m_num) begin
                fails++;
                $display("FAIL cycle_compare @%0d: dut en=%b err=%b code=%0d per=%0h high=%0h num=%0h, required en=%b err=%b code=%0d per=%0h high=%0h num=%0h",
                         cyc, o_beep_en, o_frm_err, o_err_code, o_beep_periord, o_beep_high, o_beep_num,
                         m_en, m_err, m_code, m_per, m_high, m_num);
            end
            if (o_beep_en === 1'b1) begin n_en++; en_cyc = cyc; end
            if (o_frm_err === 1'b1) begin n_err++; err_cyc = cyc; end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge i_clk);
        #1;
        i_rx_en = 1'b1;
        i_rx_data = b;
        @(posedge i_clk);
        #1;
        last_rx_cyc = cyc;
        i_rx_en = 1'b0;
    endtask

    // Sends bytes [0, upto) of a frame; byte slow_idx waits slow_gap idle cycles.
    task automatic send_frame(input logic [31:0] per, input logic [31:0] hi, input logic [15:0] num,
                              input logic [31:0] tl, input int upto, input int slow_idx, input int slow_gap);
        logic [7:0] f[18];
        logic [31:0] hw;
        hw = 32'hAA55A55A;
        for (int i = 0; i < 4; i++) begin
            f[i]      = hw[31-8*i -: 8];
            f[4+i]    = per[31-8*i -: 8];
            f[8+i]    = hi[31-8*i -: 8];
            f[14+i]   = tl[31-8*i -: 8];
        end
        f[12] = num[15:8];
        f[13] = num[7:0];
        for (int i = 0; i < upto; i++) send_byte(f[i], (i == slow_idx) ? slow_gap : GAP);
    endtask

    int e0, r0;

    initial begin
        idle(3);
        i_rst = 1'b0;
        check("reset_period", o_beep_periord, 0);
        check("reset_high", o_beep_high, 0);
        check("reset_num", {16'h0, o_beep_num}, 0);
        check("reset_code", {30'h0, o_err_code}, 0);

        // valid frames
        e0 = n_en; r0 = n_err;
        send_frame(1000, 100, 5, TAIL_OK, 18, -1, 0);
        idle(4);
        check("s1_latency", en_cyc, last_rx_cyc + 1);
        check("s1_period", o_beep_periord, 32'h3E8);
        check("s1_high", o_beep_high, 32'h64);
        check("s1_num", {16'h0, o_beep_num}, 32'h5);
        check("s1_en_count", n_en - e0, 1);
        check("s1_err_count", n_err - r0, 0);
        send_frame(5000, 1000, 5, TAIL_OK, 18, -1, 0);
        idle(4);
        check("s1b_period", o_beep_periord, 32'h1388);
        check("s1b_high", o_beep_high, 32'h3E8);

        // leading junk and header resync
        e0 = n_en;
        send_byte(8'h12, GAP);
        send_byte(8'hAA, GAP);
        send_frame(1000, 100, 5, TAIL_OK, 18, -1, 0);
        idle(4);
        check("s2_en_count", n_en - e0, 1);
        check("s2_period", o_beep_periord, 32'h3E8);

        // bad tail
        e0 = n_en; r0 = n_err;
        send_frame(7000, 70, 9, TAIL_BAD, 18, -1, 0);
        idle(4);
        check("s3_err_count", n_err - r0, 1);
        check("s3_err_cycle", err_cyc, last_rx_cyc);
        check("s3_code", {30'h0, o_err_code}, 1);
        check("s3_en_count", n_en - e0, 0);
        check("s3_period_held", o_beep_periord, 32'h3E8);

        // inter-byte timeout after header plus 3 period bytes
        r0 = n_err;
        send_frame(5000, 1000, 5, TAIL_OK, 7, -1, 0);
        idle(TMO + 5);
        check("s4_err_count", n_err - r0, 1);
        check("s4_err_cycle", err_cyc, last_rx_cyc + TMO - 1);
        check("s4_code", {30'h0, o_err_code}, 2);
        e0 = n_en;
        send_frame(5000, 1000, 5, TAIL_OK, 18, -1, 0);
        idle(4);
        check("s4_recover_period", o_beep_periord, 32'h1388);
        check("s4_recover_en", n_en - e0, 1);

        // byte landing exactly on the expiry edge wins
        e0 = n_en; r0 = n_err;
        send_frame(600, 600, 3, TAIL_OK, 18, 7, TMO - 2);
        idle(4);
        check("s4b_err_count", n_err - r0, 0);
        check("s4b_en_count", n_en - e0, 1);
        check("s4b_high_eq_period", o_beep_high, 32'd600);

        // invalid parameters
        r0 = n_err;
        send_frame(100, 200, 4, TAIL_OK, 18, -1, 0);
        idle(4);
        check("s5_code", {30'h0, o_err_code}, 3);
        check("s5_period_held", o_beep_periord, 32'd600);
        send_frame(0, 0, 4, TAIL_OK, 18, -1, 0);
        idle(4);
        check("s5_zero_err_count", n_err - r0, 2);
        check("s5_num_held", {16'h0, o_beep_num}, 3);

        // reset in the middle of a frame
        r0 = n_err;
        send_frame(1000, 100, 5, TAIL_OK, 9, -1, 0);
        i_rst = 1'b1;
        idle(1);
        i_rst = 1'b0;
        idle(TMO + 5);
        check("s6_no_err", n_err - r0, 0);
        check("s6_period_zero", o_beep_periord, 0);
        e0 = n_en;
        send_frame(1000, 100, 5, TAIL_OK, 18, -1, 0);
        idle(4);
        check("s6_en_count", n_en - e0, 1);
        check("s6_period", o_beep_periord, 32'h3E8);
        check("s6_num", {16'h0, o_beep_num}, 32'h5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
